// File: rtl/booth_mac_pipe.sv
// Pipelined radix-4 Booth / Wallace-tree multiply-accumulate with valid/ready handshake.
// Stages: Booth rows -> carry-save pair -> low-half add -> high-half add into result_o.
module booth_mac_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result_o,
  output logic               busy_o
);

  localparam int PW      = 2 * WIDTH;
  localparam int NumPp   = WIDTH / 2 + 1;
  localparam int NumRows = NumPp + 2;

  // Rows left after `lvl` levels of 3:2 compression.
  function automatic int rows_at(int lvl);
    int r;
    r = NumRows;
    for (int i = 0; i < lvl; i++) begin
      if (r > 2) r = 2 * (r / 3) + r % 3;
    end
    return r;
  endfunction

  logic adv, accept;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, ov_q, ov_d;

  // Booth recoding (S1 inputs)
  logic [1:0]      op_eff;
  logic            msub;
  logic [PW-1:0]   a_ext;
  logic [WIDTH+2:0] b_pad;
  logic [PW-1:0]   pp_d [NumPp];
  logic [PW-1:0]   pp_q [NumPp];
  logic [NumPp-1:0] neg_d, neg_q;
  logic [PW-1:0]   acc_row_d, acc_row_q;

  // Compression (S2) and final add (S3/out)
  logic [PW-1:0]    corr_row;
  logic [PW-1:0]    wt [NumRows+1][NumRows];
  logic [PW-1:0]    sum_d, sum_q, carry_d, carry_q;
  logic [WIDTH-1:0] lo_d, lo_q, hs_d, hs_q, hc_d, hc_q;
  logic             lo_c_d, lo_c_q;
  logic [PW-1:0]    result_d, result_q;

  assign adv      = ~ov_q | out_ready;
  assign accept   = in_valid & adv & ~flush;
  assign in_ready = adv;
  assign out_valid = ov_q;
  assign result_o = result_q;
  assign busy_o   = v1_q | v2_q | v3_q | ov_q;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    ov_d = ov_q;
    if (flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
      ov_d = 1'b0;
    end else if (adv) begin
      v1_d = accept;
      v2_d = v1_q;
      v3_d = v2_q;
      ov_d = v3_q;
    end
  end

  always_comb begin
    op_eff    = ACC_EN ? op_i : 2'b00;
    msub      = (op_eff == 2'b10);
    a_ext     = signed_i ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    b_pad     = {{2{signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};
    acc_row_d = (op_eff == 2'b01 || op_eff == 2'b10) ? acc_i : '0;
  end

  // MSUB flips every digit's sign so the tree sums acc + (-a*b) directly.
  for (genvar k = 0; k < NumPp; k++) begin : g_booth
    logic [2:0]    trip;
    logic          one, two, neg;
    logic [PW-1:0] mag;
    assign trip     = b_pad[2*k +: 3];
    assign one      = trip[1] ^ trip[0];
    assign two      = (trip == 3'b011) | (trip == 3'b100);
    assign neg      = (trip[2] & ~(trip[1] & trip[0])) ^ msub;
    assign mag      = one ? a_ext : (two ? {a_ext[PW-2:0], 1'b0} : '0);
    assign neg_d[k] = neg;
    assign pp_d[k]  = (neg ? ~mag : mag) << (2 * k);
    // Two's-complement +1 of each negated row lands at bit 2k of the correction row.
    assign corr_row[2*k +: 2] = {1'b0, neg_q[k]};
  end
  assign corr_row[PW-1:2*NumPp] = '0;

  for (genvar r = 0; r < NumRows; r++) begin : g_l0
    if (r < NumPp) begin : g_pp
      assign wt[0][r] = pp_q[r];
    end else if (r == NumPp) begin : g_corr
      assign wt[0][r] = corr_row;
    end else begin : g_acc
      assign wt[0][r] = acc_row_q;
    end
  end

  for (genvar l = 0; l < NumRows; l++) begin : g_lvl
    localparam int Rin   = rows_at(l);
    localparam int Nfull = (Rin > 2) ? Rin / 3 : 0;
    for (genvar g = 0; g < NumRows; g++) begin : g_row
      if (g < Nfull) begin : g_csa
        assign wt[l+1][2*g]   = wt[l][3*g] ^ wt[l][3*g+1] ^ wt[l][3*g+2];
        assign wt[l+1][2*g+1] = ((wt[l][3*g] & wt[l][3*g+1]) | (wt[l][3*g] & wt[l][3*g+2]) |
                                 (wt[l][3*g+1] & wt[l][3*g+2])) << 1;
      end
      if (g >= 3 * Nfull && g < Rin) begin : g_pass
        assign wt[l+1][g-Nfull] = wt[l][g];
      end
      if (g >= Rin - Nfull) begin : g_zero
        assign wt[l+1][g] = '0;
      end
    end
  end

  always_comb begin
    sum_d             = wt[NumRows][0];
    carry_d           = wt[NumRows][1];
    {lo_c_d, lo_d}    = {1'b0, sum_q[WIDTH-1:0]} + {1'b0, carry_q[WIDTH-1:0]};
    hs_d              = sum_q[PW-1:WIDTH];
    hc_d              = carry_q[PW-1:WIDTH];
    result_d          = {hs_q + hc_q + {{(WIDTH-1){1'b0}}, lo_c_q}, lo_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      ov_q     <= 1'b0;
      result_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      ov_q <= ov_d;
      if (adv) result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      pp_q      <= pp_d;
      neg_q     <= neg_d;
      acc_row_q <= acc_row_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      lo_q      <= lo_d;
      lo_c_q    <= lo_c_d;
      hs_q      <= hs_d;
      hc_q      <= hc_d;
    end
  end

endmodule

// File: tb/tb_booth_mac_pipe.sv
// Bench for booth_mac_pipe: a 32-bit MAC instance and a 16-bit MUL-only instance run in
// lockstep against a queue-free arithmetic reference with a four-slot latency model.
module tb_booth_mac_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        signed_i = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [63:0] acc_i = '0;

  logic        in_ready, out_valid, busy;
  logic [63:0] result;
  logic        in_ready_s, out_valid_s, busy_s;
  logic [31:0] result_s;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  booth_mac_pipe #(.WIDTH(32), .ACC_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .signed_i(signed_i), .op_i(op_i), .a_i(a_i), .b_i(b_i), .acc_i(acc_i),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result), .busy_o(busy)
  );

  booth_mac_pipe #(.WIDTH(16), .ACC_EN(1'b0)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .signed_i(signed_i), .op_i(op_i), .a_i(a_i[15:0]), .b_i(b_i[15:0]), .acc_i(acc_i[31:0]),
    .out_valid(out_valid_s), .out_ready(out_ready), .result_o(result_s), .busy_o(busy_s)
  );

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] ref32(input logic s, input logic [1:0] op,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] acc);
    logic [63:0] ax, bx, p;
    ax = s ? {{32{a[31]}}, a} : {32'b0, a};
    bx = s ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ax * bx;
    if (op == 2'b01) return acc + p;
    if (op == 2'b10) return acc - p;
    return p;
  endfunction

  function automatic logic [31:0] ref16(input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ax, bx;
    ax = s ? {{16{a[15]}}, a} : {16'b0, a};
    bx = s ? {{16{b[15]}}, b} : {16'b0, b};
    return ax * bx;
  endfunction

  // Slot 3 is the output register; everything advances together when the output is free.
  logic        m_vld [4];
  logic [63:0] m_r   [4];
  logic [31:0] m_rs  [4];

  always @(posedge clk) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < 4; i++) m_vld[i] <= 1'b0;
    end else if (!m_vld[3] || out_ready) begin
      m_vld[0] <= in_valid;
      m_r[0]   <= ref32(signed_i, op_i, a_i, b_i, acc_i);
      m_rs[0]  <= ref16(signed_i, a_i[15:0], b_i[15:0]);
      for (int i = 1; i < 4; i++) begin
        m_vld[i] <= m_vld[i-1];
        m_r[i]   <= m_r[i-1];
        m_rs[i]  <= m_rs[i-1];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("out_valid", out_valid, m_vld[3]);
      check("out_valid_s", out_valid_s, m_vld[3]);
      check("busy", busy, m_vld[0] | m_vld[1] | m_vld[2] | m_vld[3]);
      check("busy_s", busy_s, m_vld[0] | m_vld[1] | m_vld[2] | m_vld[3]);
      check("in_ready", in_ready, !m_vld[3] || out_ready);
      check("in_ready_s", in_ready_s, !m_vld[3] || out_ready);
      if (m_vld[3]) begin
        check("result", result, m_r[3]);
        check("result_s", result_s, m_rs[3]);
      end
    end
  end

  // Called at posedge+1 with an empty pipe; pins latency and result to literals.
  task automatic do_op(input string nm, input logic s, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc,
                       input logic [63:0] lit, input logic [31:0] lit_s);
    int cyc;
    bit seen;
    signed_i = s; op_i = op; a_i = a; b_i = b; acc_i = acc;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      seen = out_valid;
    end
    check({nm, " latency"}, 64'(cyc), 64'd3);
    check({nm, " result"}, result, lit);
    check({nm, " result_s"}, 64'(result_s), 64'(lit_s));
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    signed_i = 1'b0; op_i = 2'b00; a_i = a; b_i = b; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] exp_seq [4];
    exp_seq[0] = 64'd10; exp_seq[1] = 64'd18; exp_seq[2] = 64'd28; exp_seq[3] = 64'd40;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset result", result, 64'd0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset in_ready", in_ready, 1'b1);
    chk_on = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("umax", 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,
          64'hFFFF_FFFE_0000_0001, 32'hFFFE_0001);
    do_op("smin", 1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'd0,
          64'h4000_0000_0000_0000, 32'h0);
    do_op("sm1m1", 1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'd1, 32'd1);
    do_op("sm1p1", 1'b1, 2'b00, 32'hFFFF_FFFF, 32'd1, 64'd0,
          64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    do_op("madd", 1'b0, 2'b01, 32'd3, 32'd4, 64'd1, 64'hD, 32'hC);
    do_op("msub", 1'b0, 2'b10, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1);
    do_op("madd wrap", 1'b0, 2'b01, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32'd1);

    // Back-to-back with a two-cycle stall on the first result.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'(i + 2), 32'(i + 5));
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stall in_ready", in_ready, 1'b0);
      check("stall hold", result, exp_seq[0]);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("seq valid", out_valid, 1'b1);
      check("seq result", result, exp_seq[j]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("seq drained", out_valid, 1'b0);
    @(posedge clk); #1;

    // Flush with three ops in flight and a new op offered at the same edge.
    for (int i = 0; i < 3; i++) push(32'(i + 7), 32'd9);
    flush = 1'b1;
    push(32'd11, 32'd13);
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush out_valid", out_valid, 1'b0);
    check("flush busy", busy, 1'b0);
    @(posedge clk); #1;
    do_op("post flush", 1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7, 64'd0,
          64'hFFFF_FFFF_FFFF_FFEB, 32'hFFFF_FFEB);

    // Reset mid-operation, asserted alongside flush and in_valid.
    push(32'd5, 32'd6);
    push(32'd7, 32'd8);
    rst_n = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst result", result, 64'd0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    do_op("post reset", 1'b0, 2'b10, 32'd6, 32'd7, 64'd100, 64'd58, 32'd42);

    // Random traffic: every op/sign mode, random backpressure, occasional flush.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      signed_i  = 1'($urandom);
      op_i      = 2'($urandom);
      a_i       = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
      b_i       = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      acc_i     = {$urandom, $urandom};
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(63) == 0);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("final idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
